// File: rtl/demux_pkg.sv
// Shared select codes and beat type for the 3-way result mux/demux pair.
package demux_pkg;

    localparam int NUM_OUT = 3;

    localparam logic [2:0] SEL_OUT0 = 3'b000;
    localparam logic [2:0] SEL_OUT1 = 3'b001;
    localparam logic [2:0] SEL_OUT2 = 3'b010;

    typedef logic [127:0] data128_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready register slot; a load in the same cycle as a drain
// replaces the beat without a bubble.
module demux_out_slot #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            // Drain keeps the stale data; only valid drops.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_3outputs_128bits_stream.sv
// Routes one 128-bit stream to three registered valid/ready outputs.
// Optional performance counters are enabled with `define DEMUX_PERF_CNT_EN.
module demux_3outputs_128bits_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int SEL_WIDTH  = 3
`ifdef DEMUX_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_select,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    input  logic                  err_clr,
    output logic                  drop_err
`ifdef DEMUX_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  cnt_out0,
    output logic [CNT_WIDTH-1:0]  cnt_out1,
    output logic [CNT_WIDTH-1:0]  cnt_out2,
    output logic [CNT_WIDTH-1:0]  cnt_drop
`endif
);

    logic [NUM_OUT-1:0] sel_onehot;
    logic               sel_legal;
    logic               in_fire;
    logic               drop_fire;
    logic [NUM_OUT-1:0] load;

    always_comb begin
        sel_onehot = '0;
        case (in_select)
            SEL_WIDTH'(SEL_OUT0): sel_onehot = 3'b001;
            SEL_WIDTH'(SEL_OUT1): sel_onehot = 3'b010;
            SEL_WIDTH'(SEL_OUT2): sel_onehot = 3'b100;
            default:              sel_onehot = '0;
        endcase
    end

    assign sel_legal = |sel_onehot;
    // Illegal codes are always accepted so they can be dropped without stalling.
    assign in_ready  = sel_legal ? |(sel_onehot & (~out_valid | out_ready)) : 1'b1;
    assign in_fire   = in_valid & in_ready;
    assign drop_fire = in_fire & ~sel_legal;
    assign load      = {NUM_OUT{in_fire}} & sel_onehot;

    demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[0]),
        .load_data (in_data),
        .ready     (out_ready[0]),
        .valid     (out_valid[0]),
        .data      (out_data0)
    );

    demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[1]),
        .load_data (in_data),
        .ready     (out_ready[1]),
        .valid     (out_valid[1]),
        .data      (out_data1)
    );

    demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[2]),
        .load_data (in_data),
        .ready     (out_ready[2]),
        .valid     (out_valid[2]),
        .data      (out_data2)
    );

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (drop_fire) begin
            drop_err <= 1'b1;
        end else if (err_clr) begin
            drop_err <= 1'b0;
        end
    end

`ifdef DEMUX_PERF_CNT_EN
    logic [NUM_OUT-1:0] out_fire;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out0 <= '0;
            cnt_out1 <= '0;
            cnt_out2 <= '0;
            cnt_drop <= '0;
        end else begin
            if (out_fire[0]) cnt_out0 <= cnt_out0 + CNT_WIDTH'(1);
            if (out_fire[1]) cnt_out1 <= cnt_out1 + CNT_WIDTH'(1);
            if (out_fire[2]) cnt_out2 <= cnt_out2 + CNT_WIDTH'(1);
            if (drop_fire)   cnt_drop <= cnt_drop + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_3outputs_128bits_stream.sv
// Scoreboard bench for demux_3outputs_128bits_stream; DEMUX_PERF_CNT_EN adds counter checks.
module tb_demux_3outputs_128bits_stream;
    import demux_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    data128_t       in_data;
    logic [2:0]     in_select;
    logic [2:0]     out_valid;
    logic [2:0]     out_ready;
    data128_t       out_data0;
    data128_t       out_data1;
    data128_t       out_data2;
    logic           err_clr;
    logic           drop_err;
`ifdef DEMUX_PERF_CNT_EN
    logic [15:0]    cnt_out0;
    logic [15:0]    cnt_out1;
    logic [15:0]    cnt_out2;
    logic [15:0]    cnt_drop;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;

    data128_t q0[$];
    data128_t q1[$];
    data128_t q2[$];

    bit       held[3];
    data128_t held_data[3];

    demux_3outputs_128bits_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_select (in_select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .err_clr   (err_clr),
        .drop_err  (drop_err)
`ifdef DEMUX_PERF_CNT_EN
        ,
        .cnt_out0  (cnt_out0),
        .cnt_out1  (cnt_out1),
        .cnt_out2  (cnt_out2),
        .cnt_drop  (cnt_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input data128_t got, input data128_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic data128_t slot_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            default: return out_data2;
        endcase
    endfunction

    task automatic push_exp(input int k, input data128_t d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    // Monitor: pops the expected beat on every output fire and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            for (int k = 0; k < 3; k++) held[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k]) begin
                    if (held[k]) check($sformatf("stable_data%0d", k), slot_data(k), held_data[k]);
                    if (out_ready[k]) begin
                        held[k] = 1'b0;
                        checks++;
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0) ||
                            (k == 2 && q2.size() == 0)) begin
                            errors++;
                            $display("FAIL unexpected_out%0d: got %h expected no beat", k, slot_data(k));
                        end else begin
                            data128_t e;
                            case (k)
                                0:       e = q0.pop_front();
                                1:       e = q1.pop_front();
                                default: e = q2.pop_front();
                            endcase
                            if (slot_data(k) !== e) begin
                                errors++;
                                $display("FAIL out%0d_data: got %h expected %h", k, slot_data(k), e);
                            end
                        end
                    end else begin
                        held[k]      = 1'b1;
                        held_data[k] = slot_data(k);
                    end
                end else begin
                    held[k] = 1'b0;
                end
            end
        end
    end

    // Offers one beat and leaves in_valid high so calls can run back-to-back.
    task automatic send(input data128_t d, input logic [2:0] s);
        bit done = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_select = s;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (s <= 3'd2) push_exp(int'(s), d);
                @(posedge clk);
                #1;
                done = 1'b1;
                if (s <= 3'd2) begin
                    check($sformatf("latency_valid%0d", s), 128'(out_valid[s]), 128'd1);
                    check($sformatf("latency_data%0d", s), slot_data(int'(s)), d);
                end
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        data128_t a1, a2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_select = 3'd0;
        out_ready = 3'b111;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state and idle readiness for every select code
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data0", out_data0, '0);
        check("rst_out_data1", out_data1, '0);
        check("rst_out_data2", out_data2, '0);
        check("rst_drop_err", 128'(drop_err), 128'd0);
        out_ready = 3'b000;
        for (int s = 0; s < 8; s++) begin
            in_select = 3'(s);
            #1;
            check($sformatf("idle_in_ready_sel%0d", s), 128'(in_ready), 128'd1);
        end
        out_ready = 3'b111;
        @(posedge clk);
        #1;

        // Routing, back-to-back
        send({32{4'hA}}, 3'b000);
        send({32{4'hB}}, 3'b001);
        send({32{4'hC}}, 3'b010);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Backpressure isolation on output 0
        a1 = 128'h1111_0000_0000_0000_0000_0000_0000_00A1;
        a2 = 128'h2222_0000_0000_0000_0000_0000_0000_00A2;
        out_ready = 3'b110;
        send(a1, 3'b000);
        in_data   = a2;
        in_select = 3'b000;
        @(negedge clk);
        check("held_in_ready_0", 128'(in_ready), 128'd0);
        @(negedge clk);
        check("held_in_ready_1", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        idle();
        send(128'hB0B0_B0B0_1234_5678_9ABC_DEF0_0F0F_0F0F, 3'b001);
        idle();
        @(negedge clk);
        check("stall_out_data0", out_data0, a1);
        check("stall_out_valid0", 128'(out_valid[0]), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 3'b111;
        send(a2, 3'b000);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Illegal select, sticky flag and set-wins-over-clear
        send(128'hDEAD_BEEF, 3'b101);
        idle();
        check("illegal_no_valid", 128'(out_valid), 128'd0);
        check("drop_err_set", 128'(drop_err), 128'd1);
        err_clr = 1'b1;
        send(128'hBAD0, 3'b111);
        idle();
        err_clr = 1'b0;
        check("drop_err_set_wins", 128'(drop_err), 128'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("drop_err_cleared", 128'(drop_err), 128'd0);

        // Asynchronous reset while slot 1 is stalled
        out_ready = 3'b101;
        send(128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 3'b001);
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        check("rst_mid_out_data1", out_data1, '0);
        q0.delete();
        q1.delete();
        q2.delete();
        out_ready = 3'b111;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef DEMUX_PERF_CNT_EN
        // Counter wrap on output 2 and drop count
        mon_en    = 1'b0;
        in_valid  = 1'b1;
        in_select = 3'b010;
        in_data   = 128'h77;
        repeat (65535) @(posedge clk);
        #1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("cnt_out2_ffff", 128'(cnt_out2), 128'hFFFF);
        mon_en = 1'b1;
        send(128'h78, 3'b010);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("cnt_out2_wrap", 128'(cnt_out2), 128'd0);
        send(128'h1, 3'b011);
        send(128'h2, 3'b100);
        send(128'h3, 3'b110);
        idle();
        @(posedge clk);
        #1;
        check("cnt_drop_3", 128'(cnt_drop), 128'd3);
        check("cnt_out0_zero", 128'(cnt_out0), 128'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
